// File: rtl/video_layer_mixer_pkg.sv
// video_pkg: shared types, palette geometry helpers and the layer priority encoder for the video layer mixer.
package video_pkg;
  typedef enum logic {IDLE, PEND} pal_wr_state_t;
  localparam int PAL_AW = 2 + 4 + 2;
  localparam int PAL_DW = 3 + 3 + 2;
  function automatic int pal_aw(input int cref_w, input int col_w, input int vid_w);
    return cref_w + col_w + vid_w;
  endfunction
  function automatic int pal_dw(input int r_w, input int g_w, input int b_w);
    return r_w + g_w + b_w;
  endfunction
  // Lowest set index among the first n bits; n when none is set.
  function automatic int prio_enc(input logic [31:0] opaque, input int n);
    int r;
    r = n;
    for (int i = 31; i >= 0; i--)
      if (i < n && opaque[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/video_layer_mixer_if.sv
// video_layer_mixer_if: CPU palette write bus (request/ack handshake plus busy status).
interface video_layer_mixer_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          pal_wr_req;
  logic [AW-1:0] pal_wr_addr;
  logic [DW-1:0] pal_wr_data;
  logic          pal_wr_ack;
  logic          pal_busy;
  modport master (output pal_wr_req, pal_wr_addr, pal_wr_data, input pal_wr_ack, pal_busy);
  modport slave (input pal_wr_req, pal_wr_addr, pal_wr_data, output pal_wr_ack, pal_busy);
endinterface

// File: rtl/video_layer_mixer_palette_ram.sv
// palette_ram: single-write, single-sync-read palette store; a same-cycle read of the written entry returns old data.
module palette_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge clk or posedge rst)
    if (rst) rd <= '0;
    else if (re) rd <= mem[ra];
endmodule

// File: rtl/video_layer_mixer.sv
// video_layer_mixer: priority-merges NUM_LAYERS pixel streams through a CPU-writable palette into RGB with 2-tick latency.
// Build option MIXER_COLLISION_EN adds sticky per-pair layer collision flags.
module video_layer_mixer
  import video_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int COL_W      = 4,
  parameter int VID_W      = 2,
  parameter int CREF_W     = 2,
  parameter int R_W        = 3,
  parameter int G_W        = 3,
  parameter int B_W        = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_ce,
  input  logic                          blank_in,
  input  logic [NUM_LAYERS-1:0]         layer_ena,
  input  logic [NUM_LAYERS*COL_W-1:0]   layer_col,
  input  logic [NUM_LAYERS*VID_W-1:0]   layer_vid,
  input  logic [CREF_W-1:0]             cref,
  video_layer_mixer_if.slave            pal,
  output logic [R_W-1:0]                r_sig,
  output logic [G_W-1:0]                g_sig,
  output logic [B_W-1:0]                b_sig,
  output logic                          blank_out,
  output logic [$clog2(NUM_LAYERS):0]   win_layer
`ifdef MIXER_COLLISION_EN
  ,
  input  logic                          vsync_pulse,
  input  logic                          coll_clr,
  output logic [NUM_LAYERS*NUM_LAYERS-1:0] coll_flags
`endif
);
  localparam int AW   = pal_aw(CREF_W, COL_W, VID_W);
  localparam int DW   = pal_dw(R_W, G_W, B_W);
  localparam int WL_W = $clog2(NUM_LAYERS) + 1;
  logic [NUM_LAYERS-1:0]  opaque;
  logic [WL_W-1:0]        win_nxt;
  logic [COL_W+VID_W-1:0] pix_nxt;
  logic [AW-1:0]          addr1;
  logic [WL_W-1:0]        win1, win2;
  logic                   blk1, blk2;
  logic [DW-1:0]          pal_q;
  pal_wr_state_t          state, state_nxt;
  logic                   cap, pal_we, ack;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      opaque[i] = layer_ena[i] && |layer_vid[i*VID_W +: VID_W];
  end
  assign win_nxt = WL_W'(prio_enc(32'(opaque), NUM_LAYERS));
  // Background (no winner) keeps pix_nxt at zero, selecting entry {cref,0,0}.
  always_comb begin
    pix_nxt = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (win_nxt == WL_W'(i)) pix_nxt = {layer_col[i*COL_W +: COL_W], layer_vid[i*VID_W +: VID_W]};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr1 <= '0;
      win1  <= '0;
      blk1  <= 1'b0;
      win2  <= '0;
      blk2  <= 1'b0;
    end else if (pix_ce) begin
      addr1 <= {cref, pix_nxt};
      win1  <= win_nxt;
      blk1  <= blank_in;
      win2  <= win1;
      blk2  <= blk1;
    end
  palette_ram #(.AW(AW), .DW(DW)) u_ram (
    .clk(clk),
    .rst(rst),
    .re(pix_ce),
    .ra(addr1),
    .rd(pal_q),
    .we(pal_we),
    .wa(wr_addr),
    .wd(wr_data)
  );
  assign {r_sig, g_sig, b_sig} = blk2 ? '0 : pal_q;
  assign blank_out = blk2;
  assign win_layer = win2;
  // A request still high during the ack cycle is the write just committed, not a new one.
  always_comb begin
    cap       = state == IDLE && pal.pal_wr_req && !ack;
    pal_we    = state == PEND && blank_in;
    state_nxt = state == IDLE ? (cap ? PEND : IDLE) : (blank_in ? IDLE : PEND);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      ack     <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_nxt;
      ack   <= pal_we;
      if (cap) begin
        wr_addr <= pal.pal_wr_addr;
        wr_data <= pal.pal_wr_data;
      end
    end
  assign pal.pal_wr_ack = ack;
  assign pal.pal_busy   = state == PEND;
`ifdef MIXER_COLLISION_EN
  logic [NUM_LAYERS*NUM_LAYERS-1:0] coll_set;
  always_comb begin
    coll_set = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      for (int j = i + 1; j < NUM_LAYERS; j++)
        coll_set[i*NUM_LAYERS+j] = opaque[i] && opaque[j];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) coll_flags <= '0;
    else if (vsync_pulse || coll_clr) coll_flags <= '0;
    else if (pix_ce && !blank_in) coll_flags <= coll_flags | coll_set;
`endif
endmodule

// File: doc/video_layer_mixer.md
Name: video_layer_mixer

Overview:
- Parametrised successor to the fixed two-source tile/sprite mux plus palette stage.
- Merges NUM_LAYERS pixel streams by fixed priority and resolves the winner through a CPU-writable palette RAM.
- Drives the RGB DAC signals with a fixed 2-tick pixel pipeline and matching blank delay.
- Sits between the tile/object generators and the video output, in the same clock domain as the Z80 bus logic.

Parameters:
- NUM_LAYERS, 2, number of input layers; layer 0 has highest priority.
- COL_W, 4, colour-code width per layer.
- VID_W, 2, pixel-data width per layer; value 0 means transparent.
- CREF_W, 2, global palette bank select width.
- R_W, 3, red output width.
- G_W, 3, green output width.
- B_W, 2, blue output width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_ce  in  1  pixel clock enable; the pipeline advances only when high
- blank_in  in  1  composite blank aligned to the layer inputs
- layer_ena  in  NUM_LAYERS  per-layer enable; a disabled layer is treated as transparent
- layer_col  in  NUM_LAYERS*COL_W  packed colour codes; layer i at [i*COL_W +: COL_W]
- layer_vid  in  NUM_LAYERS*VID_W  packed pixel data, packed the same way
- cref  in  CREF_W  palette bank
- pal_wr_req  in  1  CPU palette write request; held until ack
- pal_wr_addr  in  CREF_W+COL_W+VID_W  palette entry address
- pal_wr_data  in  R_W+G_W+B_W  entry value {R,G,B}
- pal_wr_ack  out  1  one-cycle pulse when the write is committed
- pal_busy  out  1  high while a write is held pending
- r_sig  out  R_W  red output
- g_sig  out  G_W  green output
- b_sig  out  B_W  blue output
- blank_out  out  1  blank_in delayed to align with RGB
- win_layer  out  $clog2(NUM_LAYERS)+1  index of the winning layer, aligned to RGB; value NUM_LAYERS means background

Behaviour:
- Reset: all outputs 0; pipeline registers 0; pending write dropped. Palette RAM contents are not cleared.
- Stage 1 (on pix_ce):
  - Winner = lowest index i with layer_ena[i]=1 and layer_vid[i]!=0.
  - Register addr1 = {cref, col_i, vid_i}, win1 = i, blk1 = blank_in.
  - If no layer is opaque: addr1 = {cref, 0, 0}, win1 = NUM_LAYERS.
- Stage 2 (on pix_ce):
  - Synchronous palette read at addr1.
  - Register blk2 = blk1 and win2 = win1.
  - RGB = blk2 ? 0 : RAM data.
- Latency: exactly 2 pix_ce ticks from inputs to r/g/b/blank_out/win_layer. Outputs hold while pix_ce is low.
- Palette write handshake:
  - States: IDLE, PEND.
  - IDLE with pal_wr_req: capture addr/data and go to PEND. pal_busy=1 from the next cycle.
  - PEND with blank_in=1: write the RAM, pulse pal_wr_ack for 1 cycle, return to IDLE. This defers palette changes to blanking and prevents mid-line tearing.
  - A request seen in IDLE while blank_in=1 commits on the following cycle, so ack comes 2 cycles after req.
  - The CPU must drop req the cycle after ack. A req still high in IDLE after ack is a new write.
- Read/write same address in the same cycle: the read returns old data.
- Reset during PEND: the write is lost and no ack is issued.
- NUM_LAYERS=1 is legal; win_layer is then 1 bit wide plus the background code.

Optional Feature:
- Macro: MIXER_COLLISION_EN.
- Enabled, adds these ports:
  - vsync_pulse in 1
  - coll_clr in 1
  - coll_flags out NUM_LAYERS*NUM_LAYERS
- Enabled, behaviour:
  - On each pix_ce with blank_in=0, for every enabled opaque pair i<j, set sticky bit coll_flags[i*NUM_LAYERS+j].
  - vsync_pulse or coll_clr clears all flags. Clear wins over a set in the same cycle.
  - Flags reset to 0.
- Disabled: these ports are absent and there is no collision logic.

Decomposition:
- Package video_pkg:
  - pal_wr_state_t enum {IDLE, PEND}.
  - Localparam helpers for PAL_AW = CREF_W+COL_W+VID_W and PAL_DW = R_W+G_W+B_W.
  - A priority-encode function.
- Sub-module palette_ram: 2^PAL_AW x PAL_DW, one sync read port and one write port, read-old-data.

Test Plan:
1. Palette setup and basic lookup:
   - Write entry 0x05 = 0xE3 during blank; ack arrives 2 cycles after req.
   - Then drive layer0 col=1, vid=1, cref=0 with pix_ce always 1 → RGB = {7,0,3} two ticks later, win_layer=0.
2. Priority:
   - layer0 vid=0, layer1 col=2, vid=3 → addr 0x0B, win_layer=1.
   - Set layer0 vid=2 → layer0 wins.
   - Clear layer_ena[0] → layer1 wins again.
3. Background: all layers transparent, cref=2 → addr 0x80 read, win_layer=NUM_LAYERS.
4. Deferred write:
   - Issue req with blank_in=0 for 50 cycles → pal_busy=1, no ack, old data still output.
   - Raise blank_in → ack on the next cycle, new colour visible on the next unblanked pixel.
5. Blank and hold:
   - blank_in=1 → RGB=0 after 2 ticks.
   - With pix_ce toggling 1-of-2 cycles, latency is 2 pix_ce ticks and outputs hold between ticks.
   - Asserting rst while in PEND → no ack, outputs go to 0 immediately.
6. Collision (MIXER_COLLISION_EN, 3 layers):
   - Layers 0 and 2 opaque on the same pixel → coll_flags bit 2 set and sticky.
   - vsync_pulse clears it.
